// File: rtl/pendulum_pkg.sv
// Shared types and widths for the pendulum control loop.
package pendulum_pkg;

    localparam int unsigned E_W  = 9;
    localparam int unsigned D_W  = 10;
    localparam int unsigned P_W  = 17;
    localparam int unsigned DT_W = 18;
    localparam int unsigned S_W  = 19;
    localparam int unsigned O_W  = 8;

    localparam logic signed [O_W-1:0] SAT_MAX = 8'sd127;
    localparam logic signed [O_W-1:0] SAT_MIN = -8'sd127;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        MULT_P,
        MULT_D,
        SUM,
        DRIVE
    } state_t;

endpackage

// File: rtl/pendulum_sat_shift.sv
// Arithmetic right shift of the gain sum followed by symmetric saturation to +/-127.
module pendulum_sat_shift
    import pendulum_pkg::*;
#(
    parameter int unsigned SHIFT = 4
) (
    input  logic signed [S_W-1:0] sum,
    output logic signed [O_W-1:0] value,
    output logic                  clip
);

    logic signed [S_W-1:0] shifted;

    always_comb begin
        shifted = sum >>> SHIFT;
        value   = shifted[O_W-1:0];
        clip    = 1'b0;
        if (shifted > S_W'(SAT_MAX)) begin
            value = SAT_MAX;
            clip  = 1'b1;
        end else if (shifted < S_W'(SAT_MIN)) begin
            value = SAT_MIN;
            clip  = 1'b1;
        end
    end

endmodule

// File: rtl/pendulum_controller.sv
// Sampled PD controller for a pendulum plant; the D term is built in only when
// PENDULUM_CONTROLLER_DERIV_EN is defined (otherwise MULT_D is skipped).
module pendulum_controller
    import pendulum_pkg::*;
#(
    parameter int unsigned DIVIDE = 16,
    parameter int          KP     = 4,
    parameter int          KD     = 32,
    parameter int unsigned SHIFT  = 4
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              enable,
    input  logic signed [7:0] position,
    input  logic signed [7:0] setpoint,
    output logic signed [7:0] feedback,
    output logic              valid,
    output logic              saturated
);

    localparam int unsigned CNT_W = $clog2(DIVIDE);
    localparam logic signed [7:0] KP_S = 8'(KP);

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt;
    logic                   cnt_last;
    logic signed [E_W-1:0]  e;
    logic signed [P_W-1:0]  pterm;
    logic signed [DT_W-1:0] dterm;
    logic signed [S_W-1:0]  sum;
    logic signed [O_W-1:0]  sat_value;
    logic                   sat_clip;

    assign cnt_last = (cnt == CNT_W'(DIVIDE - 1));

    // Sample-rate divider, parked at zero while the loop is disabled.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN)
            cnt <= '0;
        else if (!enable || cnt_last)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable && cnt_last) state_next = SAMPLE;
            SAMPLE:  state_next = MULT_P;
`ifdef PENDULUM_CONTROLLER_DERIV_EN
            MULT_P:  state_next = MULT_D;
`else
            MULT_P:  state_next = SUM;
`endif
            MULT_D:  state_next = SUM;
            SUM:     state_next = DRIVE;
            DRIVE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are loaded at the end of SUM so they are visible during DRIVE.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            e         <= '0;
            pterm     <= '0;
            feedback  <= '0;
            valid     <= 1'b0;
            saturated <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                SAMPLE: e <= E_W'(setpoint) - E_W'(position);
                MULT_P: pterm <= P_W'(KP_S) * P_W'(e);
                SUM: begin
                    feedback  <= sat_value;
                    saturated <= sat_clip;
                    valid     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PENDULUM_CONTROLLER_DERIV_EN
    localparam logic signed [7:0] KD_S = 8'(KD);

    logic signed [E_W-1:0] eprev;
    logic signed [D_W-1:0] d;
    logic                  first;

    assign d = first ? '0 : D_W'(e) - D_W'(eprev);

    // Derivative history; restarts after reset or while the loop idles disabled.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            eprev <= '0;
            dterm <= '0;
            first <= 1'b1;
        end else if (state == MULT_D) begin
            dterm <= DT_W'(KD_S) * DT_W'(d);
            eprev <= e;
            first <= 1'b0;
        end else if (state == IDLE && !enable) begin
            first <= 1'b1;
        end
    end
`else
    logic unused_kd;

    assign unused_kd = ^8'(KD);
    assign dterm     = '0;
`endif

    assign sum = S_W'(pterm) + S_W'(dterm);

    pendulum_sat_shift #(
        .SHIFT(SHIFT)
    ) u_sat_shift (
        .sum  (sum),
        .value(sat_value),
        .clip (sat_clip)
    );

endmodule

// File: tb/tb_pendulum_controller.sv
// Directed bench for pendulum_controller; expectations follow the build's
// PENDULUM_CONTROLLER_DERIV_EN setting.
module tb_pendulum_controller;

    localparam int DIVIDE = 16;
`ifdef PENDULUM_CONTROLLER_DERIV_EN
    localparam int LAT    = 4;
    localparam int FB_D20 = 35;   // e=-20, d=20: (-80+640)>>>4
`else
    localparam int LAT    = 3;
    localparam int FB_D20 = -5;   // e=-20: -80>>>4
`endif

    logic              clock = 1'b0;
    logic              resetN;
    logic              enable;
    logic signed [7:0] position, setpoint, pos2, sp2;
    logic signed [7:0] feedback, fb2;
    logic              valid, valid2, saturated, sat2;

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    pendulum_controller #(.DIVIDE(DIVIDE)) u_dut (
        .clock(clock), .resetN(resetN), .enable(enable),
        .position(position), .setpoint(setpoint),
        .feedback(feedback), .valid(valid), .saturated(saturated)
    );

    pendulum_controller #(.DIVIDE(DIVIDE), .KP(127)) u_sat (
        .clock(clock), .resetN(resetN), .enable(enable),
        .position(pos2), .setpoint(sp2),
        .feedback(fb2), .valid(valid2), .saturated(sat2)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset;
        resetN = 1'b0; enable = 1'b0;
        setpoint = '0; position = '0; sp2 = '0; pos2 = '0;
        tick(2);
        resetN = 1'b1;
    endtask

    // Returns the number of rising edges until valid is seen, or bound+1 on timeout.
    task automatic wait_valid(input bit sel, input int bound, output int n);
        n = bound + 1;
        for (int i = 1; i <= bound; i++) begin
            tick(1);
            if ((sel ? valid2 : valid) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        resetN = 1'b0; enable = 1'b0;
        setpoint = 8'sd5; position = -8'sd7; sp2 = '0; pos2 = '0;
        tick(2);
        vectors++; if (feedback !== 8'sd0) begin errors++; $display("FAIL reset_feedback got %0d expected 0", feedback); end
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", valid); end
        vectors++; if (saturated !== 1'b0) begin errors++; $display("FAIL reset_saturated got %b expected 0", saturated); end
    endtask

    task automatic test_first_and_derivative;
        int n;
        do_reset();
        setpoint = 8'sd0; position = 8'sd40; enable = 1'b1;
        wait_valid(1'b0, 40, n);
        vectors++; if (n !== DIVIDE + LAT) begin errors++; $display("FAIL first_latency got %0d expected %0d", n, DIVIDE + LAT); end
        vectors++; if (feedback !== -10) begin errors++; $display("FAIL first_feedback got %0d expected -10", feedback); end
        vectors++; if (saturated !== 1'b0) begin errors++; $display("FAIL first_saturated got %b expected 0", saturated); end
        position = 8'sd20;
        tick(1);
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL valid_pulse_width got %b expected 0", valid); end
        vectors++; if (feedback !== -10) begin errors++; $display("FAIL feedback_hold got %0d expected -10", feedback); end
        wait_valid(1'b0, 40, n);
        vectors++; if (n !== DIVIDE - 1) begin errors++; $display("FAIL sample_spacing got %0d expected %0d", n, DIVIDE - 1); end
        vectors++; if (feedback !== FB_D20) begin errors++; $display("FAIL deriv_feedback got %0d expected %0d", feedback, FB_D20); end
        vectors++; if (saturated !== 1'b0) begin errors++; $display("FAIL deriv_saturated got %b expected 0", saturated); end
    endtask

    task automatic test_saturation;
        int n;
        do_reset();
        sp2 = 8'sd127; pos2 = -8'sd128; enable = 1'b1;
        wait_valid(1'b1, 40, n);
        vectors++; if (n !== DIVIDE + LAT) begin errors++; $display("FAIL sat_latency got %0d expected %0d", n, DIVIDE + LAT); end
        vectors++; if (fb2 !== 8'sd127) begin errors++; $display("FAIL sat_pos_feedback got %0d expected 127", fb2); end
        vectors++; if (sat2 !== 1'b1) begin errors++; $display("FAIL sat_pos_flag got %b expected 1", sat2); end
        sp2 = -8'sd128; pos2 = 8'sd127;
        wait_valid(1'b1, 40, n);
        vectors++; if (n !== DIVIDE) begin errors++; $display("FAIL sat_spacing got %0d expected %0d", n, DIVIDE); end
        vectors++; if (fb2 !== -127) begin errors++; $display("FAIL sat_neg_feedback got %0d expected -127", fb2); end
        vectors++; if (sat2 !== 1'b1) begin errors++; $display("FAIL sat_neg_flag got %b expected 1", sat2); end
    endtask

    task automatic test_reset_mid;
        int n;
        do_reset();
        setpoint = 8'sd0; position = 8'sd40; enable = 1'b1;
        wait_valid(1'b0, 40, n);
        vectors++; if (feedback !== -10) begin errors++; $display("FAIL rmid_pre_feedback got %0d expected -10", feedback); end
        tick(17 - LAT);
        resetN = 1'b0;
        #1;
        vectors++; if (feedback !== 8'sd0) begin errors++; $display("FAIL rmid_feedback got %0d expected 0", feedback); end
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b expected 0", valid); end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_no_pulse got %b expected 0", valid); end
        end
        position = 8'sd20;
        resetN = 1'b1;
        wait_valid(1'b0, 40, n);
        vectors++; if (n !== DIVIDE + LAT) begin errors++; $display("FAIL rmid_latency got %0d expected %0d", n, DIVIDE + LAT); end
        vectors++; if (feedback !== -5) begin errors++; $display("FAIL rmid_d0_feedback got %0d expected -5", feedback); end
    endtask

    task automatic test_enable_drop;
        int n;
        do_reset();
        setpoint = 8'sd0; position = 8'sd40; enable = 1'b1;
        wait_valid(1'b0, 40, n);
        vectors++; if (feedback !== -10) begin errors++; $display("FAIL edrop_pre_feedback got %0d expected -10", feedback); end
        position = 8'sd20;
        tick(17 - LAT);
        enable = 1'b0;
        wait_valid(1'b0, 10, n);
        vectors++; if (n !== LAT - 1) begin errors++; $display("FAIL edrop_inflight got %0d expected %0d", n, LAT - 1); end
        vectors++; if (feedback !== FB_D20) begin errors++; $display("FAIL edrop_feedback got %0d expected %0d", feedback, FB_D20); end
        wait_valid(1'b0, 3 * DIVIDE, n);
        vectors++; if (n !== 3 * DIVIDE + 1) begin errors++; $display("FAIL edrop_quiet got %0d expected %0d", n, 3 * DIVIDE + 1); end
        vectors++; if (feedback !== FB_D20) begin errors++; $display("FAIL edrop_hold got %0d expected %0d", feedback, FB_D20); end
        position = 8'sd30;
        enable = 1'b1;
        wait_valid(1'b0, 40, n);
        vectors++; if (n !== DIVIDE + LAT) begin errors++; $display("FAIL reenable_latency got %0d expected %0d", n, DIVIDE + LAT); end
        vectors++; if (feedback !== -8) begin errors++; $display("FAIL reenable_d0_feedback got %0d expected -8", feedback); end
    endtask

    initial begin
        test_reset();
        test_first_and_derivative();
        test_saturation();
        test_reset_mid();
        test_enable_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
